decoder: RTL and testbench

Decode stage directly downstream of the PC/instruction-fetch stage.
- Consumes the fetched 32-bit RV32I instruction and its PC.
- Owns the 32x32 register file and generates immediates and control signals for the ALU, memory and write-back stages.
- Runs a small ecall halt FSM that drives stop_flag back to the fetch stage, so the PC holds while the core is halted.

---
 rtl/rv_pkg.sv | 46 ++++
 rtl/regfile.sv | 35 +++
 rtl/decoder.sv | 136 +++++++++++++
 tb/tb_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, the ecall word, halt-FSM state
// encoding, immediate formats and the immediate generator.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_SKIP = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
      logic [31:0] r;
      case (fmt)
         IMM_I:   r = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   r = {ins[31:12], 12'b0};
         IMM_J:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: r = 32'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Ports: clk, rst_n (async active-low), raddr1/raddr2 -> rdata1/rdata2,
//        we/waddr/wdata write on posedge. x0 reads 0; x2 resets to RESET_SP.
module regfile #(
   parameter logic [31:0] RESET_SP = 32'h0000_7FFC,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == 2) ? RESET_SP : 32'b0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   // No write bypass: a same-cycle read sees the pre-write value.
   assign rdata1 = (raddr1 == 5'd0) ? 32'b0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'b0 : regs[raddr2];

endmodule

// File: rtl/decoder.sv
// RV32I decode stage: control decode, immediate generation, register file and
// the ecall halt FSM that holds the fetch PC via stop_flag.
// Inputs : clk, rst_n, inst, pc_in, wr_data, resume.
// Outputs: rs1_data, rs2_data, imm, funct3, funct7_5, reg_write, mem_read,
//          mem_write, mem_to_reg, alu_src, branch, jal, jalr, lui, auipc,
//          stop_flag, illegal.
module decoder
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_SP = 32'h0000_7FFC,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic [31:0] pc_in,
   input  logic [31:0] wr_data,
   input  logic        resume,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic [31:0] imm,
   output logic [2:0]  funct3,
   output logic        funct7_5,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic        branch,
   output logic        jal,
   output logic        jalr,
   output logic        lui,
   output logic        auipc,
   output logic        stop_flag,
   output logic        illegal
);

   state_e   state_q, state_d;
   imm_fmt_e imm_fmt;
   logic     dec_reg_write;
   logic     is_ecall;

   // Link and auipc sums are formed downstream; the PC is not needed here.
   logic unused_pc;
   assign unused_pc = ^pc_in;

   assign is_ecall = (inst == ECALL_WORD);
   assign funct3   = inst[14:12];
   assign funct7_5 = inst[30];

   always_comb begin
      dec_reg_write = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      branch        = 1'b0;
      jal           = 1'b0;
      jalr          = 1'b0;
      lui           = 1'b0;
      auipc         = 1'b0;
      illegal       = 1'b0;
      imm_fmt       = IMM_NONE;
      case (inst[6:0])
         OP_R:      dec_reg_write = 1'b1;
         OP_I:      begin dec_reg_write = 1'b1; alu_src = 1'b1; imm_fmt = IMM_I; end
         OP_LOAD: begin
            dec_reg_write = 1'b1;
            mem_read      = 1'b1;
            mem_to_reg    = 1'b1;
            alu_src       = 1'b1;
            imm_fmt       = IMM_I;
         end
         OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; imm_fmt = IMM_S; end
         OP_BRANCH: begin branch = 1'b1; imm_fmt = IMM_B; end
         OP_JAL:    begin dec_reg_write = 1'b1; jal = 1'b1; imm_fmt = IMM_J; end
         OP_JALR: begin
            dec_reg_write = 1'b1;
            jalr          = 1'b1;
            alu_src       = 1'b1;
            imm_fmt       = IMM_I;
         end
         OP_LUI:    begin dec_reg_write = 1'b1; lui = 1'b1; alu_src = 1'b1; imm_fmt = IMM_U; end
         OP_AUIPC:  begin dec_reg_write = 1'b1; auipc = 1'b1; alu_src = 1'b1; imm_fmt = IMM_U; end
         // Only ecall is implemented in the SYSTEM space; it drives no controls.
         OP_SYSTEM: illegal = !is_ecall;
         default:   illegal = 1'b1;
      endcase
   end

   assign imm       = gen_imm(imm_fmt, inst);
   assign reg_write = dec_reg_write && (state_q != ST_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stop_flag = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            // Raised combinationally so fetch holds in the ecall's own cycle.
            stop_flag = is_ecall;
            if (is_ecall) state_d = ST_HALT;
         end
         ST_HALT: begin
            stop_flag = 1'b1;
            if (resume) state_d = ST_SKIP;
         end
         // One cycle with the stop released lets the held PC step past the ecall.
         ST_SKIP: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   regfile #(
      .RESET_SP (RESET_SP),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (inst[19:15]),
      .raddr2 (inst[24:20]),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data),
      .we     (reg_write),
      .waddr  (inst[11:7]),
      .wdata  (wr_data)
   );

endmodule

// File: tb/tb_decoder.sv
// Randomised scoreboard bench for the decoder with a behavioural reference model.
module tb_decoder;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [15:0] ctrl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst, pc_in, wr_data;
   logic        resume;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [2:0]  funct3;
   logic        funct7_5, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
   logic        branch, jal, jalr, lui, auipc, stop_flag, illegal;

   always #5 clk = ~clk;

   decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst       (inst),
      .pc_in      (pc_in),
      .wr_data    (wr_data),
      .resume     (resume),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .imm        (imm),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .alu_src    (alu_src),
      .branch     (branch),
      .jal        (jal),
      .jalr       (jalr),
      .lui        (lui),
      .auipc      (auipc),
      .stop_flag  (stop_flag),
      .illegal    (illegal)
   );

   // Reference model state: architectural registers plus halt status.
   logic [31:0] m_regs [32];
   bit          m_halt, m_skip;
   exp_t        q[$];
   int          checks = 0;
   int          passes = 0;
   logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 2) ? 32'h0000_7FFC : 32'h0;
      m_halt = 1'b0;
      m_skip = 1'b0;
   endfunction

   function automatic bit known_op(input logic [6:0] op);
      for (int i = 0; i < 10; i++) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jal, jalr, lui, auipc}
   function automatic logic [9:0] ref_ctrl(input logic [31:0] w);
      case (w[6:0])
         7'b0110011: return 10'b1000000000;
         7'b0010011: return 10'b1000100000;
         7'b0000011: return 10'b1101100000;
         7'b0100011: return 10'b0010100000;
         7'b1100011: return 10'b0000010000;
         7'b1101111: return 10'b1000001000;
         7'b1100111: return 10'b1000100100;
         7'b0110111: return 10'b1000100010;
         7'b0010111: return 10'b1000100001;
         default:    return 10'b0;
      endcase
   endfunction

   // Immediates as signed field values, widened by signed assignment.
   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      logic signed [11:0] v12;
      logic signed [12:0] v13;
      logic signed [20:0] v21;
      logic [31:0]        r;
      case (w[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin v12 = w[31:20]; r = v12; end
         7'b0100011: begin v12 = {w[31:25], w[11:7]}; r = v12; end
         7'b1100011: begin v13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = v13; end
         7'b1101111: begin v21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = v21; end
         7'b0110111, 7'b0010111: r = w & 32'hFFFF_F000;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic step(input logic [31:0] w, input logic [31:0] wd, input logic rs,
                       input bit do_rst);
      exp_t       e;
      logic [9:0] c;
      bit         ill, ec, rw, stop;
      @(posedge clk);
      #2;
      if (do_rst) begin
         resume = rs;
         rst_n  = 1'b0;
         #1;
         model_reset();
         rst_n  = 1'b1;
      end
      inst    = w;
      wr_data = wd;
      resume  = rs;
      pc_in   = $urandom;
      ec      = (w == 32'h0000_0073);
      ill     = !known_op(w[6:0]) || (w[6:0] == 7'b1110011 && !ec);
      c       = ref_ctrl(w);
      rw      = c[9] && !m_halt;
      stop    = m_halt || (!m_skip && ec);
      e.rs1   = m_regs[w[19:15]];
      e.rs2   = m_regs[w[24:20]];
      e.imm   = ill ? 32'h0 : ref_imm(w);
      e.ctrl  = {w[14:12], w[30], rw, c[8:0], stop, ill};
      q.push_back(e);
      if (rw && w[11:7] != 5'd0) m_regs[w[11:7]] = wd;
      if (m_halt) begin
         if (rs) begin m_halt = 1'b0; m_skip = 1'b1; end
      end else if (m_skip) begin
         m_skip = 1'b0;
      end else if (ec) begin
         m_halt = 1'b1;
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int          k;
      k = $urandom_range(0, 13);
      w = $urandom;
      if (k < 10) begin
         w[6:0] = ops[k];
      end else if (k == 10 || k == 11) begin
         w = 32'h0000_0073;
      end else begin
         while (known_op(w[6:0])) w = $urandom;
      end
      return w;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         cmp("rs1_data", rs1_data, e.rs1);
         cmp("rs2_data", rs2_data, e.rs2);
         cmp("imm", imm, e.imm);
         cmp("controls", {16'h0, funct3, funct7_5, reg_write, mem_read, mem_write, mem_to_reg,
                          alu_src, branch, jal, jalr, lui, auipc, stop_flag, illegal},
             {16'h0, e.ctrl});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      inst    = 32'h0;
      pc_in   = 32'h0;
      wr_data = 32'h0;
      resume  = 1'b0;
      model_reset();
      step(32'h0051_0033, 32'h1234_5678, 1'b0, 1'b1); // reset values of x2 and x5
      step(32'h0050_0093, 32'h0000_0005, 1'b0, 1'b0); // addi x1, x0, 5
      step(32'h0000_8033, 32'hDEAD_BEEF, 1'b0, 1'b0); // reads x1, writes x0
      step(32'h0070_0013, 32'h0000_0007, 1'b0, 1'b0); // addi x0, x0, 7
      step(32'h0000_0033, 32'h0000_0000, 1'b0, 1'b0); // reads x0
      step(32'hFE11_2E23, 32'h5555_5555, 1'b0, 1'b0); // sw x1, -4(x2)
      step(32'hFE00_0EE3, 32'h6666_6666, 1'b0, 1'b0); // beq x0, x0, -4
      step(32'h0000_0073, 32'h7777_7777, 1'b0, 1'b0); // ecall enters HALT
      step(32'h0010_0093, 32'h0000_0099, 1'b0, 1'b0); // addi blocked while halted
      step(32'h0000_0073, 32'h0, 1'b1, 1'b0);         // resume -> SKIP
      step(32'h0000_0073, 32'h0, 1'b0, 1'b0);         // ecall ignored in SKIP
      step(32'h0000_80B3, 32'h0000_0042, 1'b0, 1'b0); // back in RUN, reads x1
      step(32'h0000_0073, 32'h0, 1'b0, 1'b0);         // halt again
      step(32'h0001_0033, 32'h0, 1'b1, 1'b1);         // reset with resume high
      step(32'h0000_0033, 32'h0, 1'b1, 1'b0);         // resume in RUN ignored
      step(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0, 1'b0); // illegal, no write
      step(32'h000F_80B3, 32'h0, 1'b0, 1'b0);         // x31 still reset value
      for (int n = 0; n < 600; n++) begin
         step(rand_inst(), $urandom, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 149) == 0));
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
